dma_hold_master: RTL and testbench
==================================

Name: dma_hold_master

Overview:
- Bus-master DMA engine; the requesting end of the CPU hold/holdACK handshake that the main decoder acknowledges.
- Software programs source, destination and length through a small register window, like the timer's, then sets start.
- The block raises hold and waits for holdACK. It then copies 32-bit words through the data-memory port: asynchronous read, write on the clock edge.
- It drops hold, sets a sticky done flag and pulses an interrupt.

Parameters:
- wide, 32, data/address width.
- A_SRC, 5'b11000, register address of source pointer.
- A_DST, 5'b11001, register address of destination pointer.
- A_LEN, 5'b11010, register address of word count.
- A_CTRL, 5'b11011, register address of control/status.
- LEN_BITS, 16, width of word-count register; upper dataIn bits ignored.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- we  in  1  register write strobe from CPU.
- addr  in  5  register address.
- dataIn  in  wide  register write data.
- rdata  out  wide  combinational readback of the register selected by addr; 0 for unmapped addresses.
- hold  out  1  bus request to CPU.
- holdACK  in  1  bus grant from CPU.
- mem_a  out  wide  byte address to dmem.
- mem_we  out  1  dmem write enable.
- mem_d  out  wide  dmem write data.
- mem_q  in  wide  dmem asynchronous read data.
- busy  out  1  high whenever state != IDLE.
- done_irq  out  1  one-cycle pulse on completion.

Behaviour:
- Reset (asynchronous, active-high) values:
  - src, dst, len, buffer = 0.
  - state = IDLE; done flag = 0.
  - hold, mem_we, busy, done_irq = 0; mem_a = 0; mem_d = 0.
- Register file:
  - A_SRC, A_DST and A_LEN are writable only in IDLE; writes while busy are ignored.
  - A_CTRL write semantics:
    - bit0 = start.
    - bit2 = clear done, honoured in any state.
  - A_CTRL read value: {29'b0, done, busy, 1'b0}.
  - Pointers are byte addresses and advance by 4 per word; bits [1:0] pass through unchanged.
  - Pointer wrap: 32'hFFFFFFFC + 4 = 0, no error.
- State machine (registered state, Moore outputs):
  - IDLE: on a start write with len != 0, clear done and go to REQ. With len == 0, set done, pulse done_irq on the next cycle and stay in IDLE; hold is never raised.
  - REQ: hold = 1. When holdACK = 1 at the clock edge, go to RD.
  - RD: hold = 1, mem_a = src. At the edge:
    - If holdACK = 1: buffer <= mem_q, go to WR.
    - If holdACK = 0 (grant withdrawn): go to REQ; no pointer change.
  - WR: hold = 1, mem_a = dst, mem_d = buffer, mem_we = 1. WR always completes once entered. At the edge:
    - src += 4, dst += 4, len -= 1.
    - If the new len == 0, go to DONE; else go to RD.
  - DONE: hold = 0, mem_we = 0. Next edge: set done, pulse done_irq for exactly one cycle, return to IDLE.
- Timing:
  - 2 cycles per word while granted.
  - Total = 1 (REQ, with immediate grant) + 2N + 1 (DONE) cycles from start to done_irq.
- Bus discipline: mem_we is high only in WR; mem_a/mem_d are 0 outside RD/WR.
- Simultaneous events:
  - A start write in the same cycle as a clear-done write: start wins; done ends cleared.
  - A start write while busy is ignored.
- Reset mid-transfer drops hold and mem_we immediately (asynchronously). Partially copied memory is left as is.

Optional Feature:
- Macro DMA_FILL_EN.
- With it, A_CTRL bit1 = fill mode, latched at start:
  - RD is skipped; the state machine goes REQ -> WR and WR -> WR.
  - mem_d = src register value (the fill pattern).
  - src is not incremented.
  - 1 cycle per word.
  - A grant drop in WR finishes the current word, then returns to REQ.
- Without it, bit1 is ignored, reads back 0, and the fill state logic is absent.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=3'd0, REQ=3'd1, RD=3'd2, WR=3'd3, DONE=3'd4.
  - register address constants A_SRC..A_CTRL.
  - CTRL bit-index constants START=0, FILL=1, CLRDONE=2.
- One natural sub-module: dma_regs, holding the register window, readback mux and write-while-busy gating.
- The state machine and datapath stay in the top.

Test Plan:
- Basic copy:
  - Stimulus: dmem[0x100..0x10C] = 11,22,33,44; program src=0x100, dst=0x200, len=4, start; holdACK tied to hold one cycle later.
  - Response: dmem[0x200..0x20C] = 11,22,33,44; done_irq exactly one pulse, 11 cycles after start; hold low afterwards.
- Zero length:
  - Stimulus: len=0, start.
  - Response: hold never rises, done=1, one done_irq pulse.
- Grant withdrawal:
  - Stimulus: len=3; drop holdACK for 5 cycles during the second RD.
  - Response: no mem_we during the gap; copy resumes at the correct src/dst; final data matches; pointers = base+12.
- Busy protection:
  - Stimulus: write A_DST=0x400 and start again mid-transfer.
  - Response: destination unchanged; exactly one done_irq.
- Async reset:
  - Stimulus: assert rst mid-WR between clock edges.
  - Response: hold, mem_we, busy = 0 within the same cycle; rdata at A_CTRL = 0.
- Fill mode (DMA_FILL_EN):
  - Stimulus: src=32'hDEADBEEF, dst=0x300, len=3, ctrl=3'b011.
  - Response: 3 words of DEADBEEF written on consecutive cycles; no reads.

Source files
------------

// File: rtl/dma_hold_master_pkg.sv
// Shared constants for the hold/holdACK DMA master: widths, register map,
// control bit positions, state encoding and the pointer-advance helper.
package dma_hold_master_pkg;

   localparam int wide     = 32;
   localparam int LEN_BITS = 16;

   localparam logic [4:0] A_SRC  = 5'b11000;
   localparam logic [4:0] A_DST  = 5'b11001;
   localparam logic [4:0] A_LEN  = 5'b11010;
   localparam logic [4:0] A_CTRL = 5'b11011;

   localparam int START   = 0;
   localparam int FILL    = 1;
   localparam int CLRDONE = 2;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      RD   = 3'd2,
      WR   = 3'd3,
      DONE = 3'd4
   } state_t;

   // Word step on a byte pointer; the byte-offset bits ride along untouched
   // and the word part wraps silently at the top of the address space.
   function automatic logic [wide-1:0] ptr_next(input logic [wide-1:0] p);
      return {p[wide-1:2] + (wide-2)'(1), p[1:0]};
   endfunction

endpackage

// File: rtl/dma_hold_master_if.sv
// CPU register window, hold/holdACK handshake and data-memory port of the
// DMA master. The DMA side uses modport master; the CPU/memory side uses slave.
interface dma_hold_master_if;
   import dma_hold_master_pkg::*;

   logic            we;
   logic [4:0]      addr;
   logic [wide-1:0] dataIn;
   logic [wide-1:0] rdata;
   logic            hold;
   logic            holdACK;
   logic [wide-1:0] mem_a;
   logic            mem_we;
   logic [wide-1:0] mem_d;
   logic [wide-1:0] mem_q;
   logic            busy;
   logic            done_irq;

   modport master (
      input  we, addr, dataIn, holdACK, mem_q,
      output rdata, hold, mem_a, mem_we, mem_d, busy, done_irq
   );

   modport slave (
      output we, addr, dataIn, holdACK, mem_q,
      input  rdata, hold, mem_a, mem_we, mem_d, busy, done_irq
   );

endinterface

// File: rtl/dma_hold_master_regs.sv
// Register window of the DMA master: source/destination pointers, word count,
// sticky done flag and the readback mux. Software writes to the pointers and
// count land only while idle; while a transfer runs the state machine owns them.
module dma_regs
   import dma_hold_master_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [4:0]          addr,
   input  logic [wide-1:0]     dataIn,
   input  logic                busy,
   input  logic                adv,
   input  logic                adv_src,
   input  logic                set_done,
   output logic                start_req,
   output logic [wide-1:0]     src,
   output logic [wide-1:0]     dst,
   output logic [LEN_BITS-1:0] len,
   output logic [wide-1:0]     rdata
);

   logic ctrl_wr;
   logic done;

   assign ctrl_wr   = we && (addr == A_CTRL);
   assign start_req = ctrl_wr && dataIn[START] && !busy;

   // Pointers and count: software loads when idle, word steps from the engine.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src <= '0;
         dst <= '0;
         len <= '0;
      end else if (adv) begin
         dst <= ptr_next(dst);
         len <= len - LEN_BITS'(1);
         if (adv_src)
            src <= ptr_next(src);
      end else if (we && !busy) begin
         case (addr)
            A_SRC:   src <= dataIn;
            A_DST:   dst <= dataIn;
            A_LEN:   len <= dataIn[LEN_BITS-1:0];
            default: ;
         endcase
      end
   end

   // Sticky done: a start decides it outright (set for an empty job, cleared
   // otherwise), so a start beats a clear-done arriving in the same write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         done <= 1'b0;
      else if (start_req)
         done <= (len == '0);
      else if (set_done)
         done <= 1'b1;
      else if (ctrl_wr && dataIn[CLRDONE])
         done <= 1'b0;
   end

   // Combinational readback; unmapped addresses read as zero.
   always_comb begin
      rdata = '0;
      case (addr)
         A_SRC:   rdata = src;
         A_DST:   rdata = dst;
         A_LEN:   rdata = {{(wide-LEN_BITS){1'b0}}, len};
         A_CTRL:  rdata = {{(wide-3){1'b0}}, done, busy, 1'b0};
         default: rdata = '0;
      endcase
   end

endmodule

// File: rtl/dma_hold_master.sv
// Bus-master DMA engine on the CPU hold/holdACK handshake. Requests the bus,
// copies len 32-bit words src -> dst through the data-memory port (async read,
// clocked write), releases the bus, sets done and pulses done_irq.
// Optional fill mode (macro DMA_FILL_EN): CTRL bit1 at start makes the engine
// write the src register value to len destination words, one word per cycle.
//
// state | meaning
// IDLE  | waiting for a start write
// REQ   | hold raised, waiting for holdACK
// RD    | src on mem_a, word captured into buffer when granted
// WR    | dst on mem_a, word written, pointers and count step
// DONE  | bus released; next edge sets done and pulses done_irq
module dma_hold_master
   import dma_hold_master_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   dma_hold_master_if.master  bus
);

   state_t                state;
   state_t                state_nx;
   logic [wide-1:0]       src;
   logic [wide-1:0]       dst;
   logic [wide-1:0]       buffer;
   logic [LEN_BITS-1:0]   len;
   logic                  start_req;
   logic                  start_go;
   logic                  start_zero;
   logic                  fill_q;
   logic                  irq_q;

   dma_regs u_regs (
      .clk       (clk),
      .rst       (rst),
      .we        (bus.we),
      .addr      (bus.addr),
      .dataIn    (bus.dataIn),
      .busy      (bus.busy),
      .adv       (state == WR),
      .adv_src   (!fill_q),
      .set_done  (state == DONE),
      .start_req (start_req),
      .src       (src),
      .dst       (dst),
      .len       (len),
      .rdata     (bus.rdata)
   );

   assign start_go   = start_req && (len != '0);
   assign start_zero = start_req && (len == '0);

`ifdef DMA_FILL_EN
   // Fill mode is sampled once, on the accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         fill_q <= 1'b0;
      else if (start_go)
         fill_q <= bus.dataIn[FILL];
   end
`else
   assign fill_q = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next state. WR never aborts; a lost grant is only noticed in RD (copy)
   // or after the current word (fill).
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start_go) state_nx = REQ;
         REQ:  if (bus.holdACK) state_nx = fill_q ? WR : RD;
         RD:   state_nx = bus.holdACK ? WR : REQ;
         WR: begin
            if (len == LEN_BITS'(1))
               state_nx = DONE;
            else if (!fill_q)
               state_nx = RD;
            else if (bus.holdACK)
               state_nx = WR;
            else
               state_nx = REQ;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Read word capture while granted in RD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         buffer <= '0;
      else if (state == RD && bus.holdACK)
         buffer <= bus.mem_q;
   end

   // One-cycle completion pulse, for a finished job or an empty start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         irq_q <= 1'b0;
      else
         irq_q <= (state == DONE) || start_zero;
   end

   // Moore outputs; the memory port is driven only in RD/WR.
   always_comb begin
      bus.hold   = 1'b0;
      bus.mem_a  = '0;
      bus.mem_d  = '0;
      bus.mem_we = 1'b0;
      case (state)
         REQ: bus.hold = 1'b1;
         RD: begin
            bus.hold  = 1'b1;
            bus.mem_a = src;
         end
         WR: begin
            bus.hold   = 1'b1;
            bus.mem_a  = dst;
            bus.mem_d  = fill_q ? src : buffer;
            bus.mem_we = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.busy     = (state != IDLE);
   assign bus.done_irq = irq_q;

endmodule

// File: tb/tb_dma_hold_master.sv
// Bench for dma_hold_master: directed scenarios plus randomized transfers,
// checked against a transaction-level model (expected write list built from
// the bench memory at start time) and a per-cycle bus monitor.
module tb_dma_hold_master;
   import dma_hold_master_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   dma_hold_master_if ifc();

   dma_hold_master dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   // data memory: 1024 words, word index = byte address [11:2]
   logic [31:0] mem [0:1023];
   logic        pre_en = 1'b0;
   logic [9:0]  pre_a  = '0;
   logic [31:0] pre_d  = '0;

   assign ifc.mem_q = mem[ifc.mem_a[11:2]];

   always @(posedge clk) begin
      if (ifc.mem_we) mem[ifc.mem_a[11:2]] <= ifc.mem_d;
      if (pre_en)     mem[pre_a] <= pre_d;
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk(act === exp, nm, act, exp);
   endtask

   task automatic chk_bit(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // reference model: one entry per word the DMA still owes
   typedef struct {
      logic [31:0] rd_a;
      logic [31:0] wr_a;
      logic [31:0] d;
      bit          noread;
   } xfer_t;
   xfer_t expq[$];

   // grant driver: holdACK follows hold immediately or one cycle late,
   // with an optional 5-cycle withdrawal triggered by a given read address
   int          ack_lag  = 1;
   int          gap_cnt  = 0;
   bit          gap_arm  = 1'b0;
   logic [31:0] gap_addr = '0;
   logic        hold_seen = 1'b0;

   initial begin
      ifc.holdACK = 1'b0;
      forever begin
         @(negedge clk);
         if (gap_arm && ifc.hold && !ifc.mem_we && ifc.mem_a == gap_addr) begin
            gap_cnt = 5;
            gap_arm = 1'b0;
         end
         if (gap_cnt > 0) begin
            chk_bit("gap_no_we", ifc.mem_we, 1'b0);
            gap_cnt--;
            ifc.holdACK = 1'b0;
         end else begin
            ifc.holdACK = (ack_lag != 0) ? hold_seen : ifc.hold;
         end
         hold_seen = ifc.hold;
      end
   end

   // per-cycle monitor
   int   irq_cnt  = 0;
   int   hold_cnt = 0;
   logic irq_prev = 1'b0;

   initial begin
      xfer_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (ifc.done_irq) irq_cnt++;
            if (ifc.hold) hold_cnt++;
            chk(!(ifc.done_irq && irq_prev), "irq_one_cycle", 32'(ifc.done_irq), 32'(0));
            chk(ifc.busy || !ifc.hold, "hold_implies_busy", 32'(ifc.busy), 32'(1));
            if (ifc.mem_we) begin
               chk_bit("we_needs_hold", ifc.hold, 1'b1);
               chk(expq.size() != 0, "write_expected", ifc.mem_a, 32'(expq.size()));
               if (expq.size() != 0) begin
                  e = expq.pop_front();
                  chk_eq("wr_addr", ifc.mem_a, e.wr_a);
                  chk_eq("wr_data", ifc.mem_d, e.d);
               end
            end else begin
               chk_eq("idle_mem_d", ifc.mem_d, 32'h0);
               if (!ifc.hold)
                  chk_eq("idle_mem_a", ifc.mem_a, 32'h0);
               else if (ifc.mem_a != 32'h0) begin
                  chk(expq.size() != 0 && !expq[0].noread, "read_expected", ifc.mem_a, 32'(expq.size()));
                  if (expq.size() != 0 && !expq[0].noread)
                     chk_eq("rd_addr", ifc.mem_a, expq[0].rd_a);
               end
            end
            irq_prev = ifc.done_irq;
         end else begin
            irq_prev = 1'b0;
         end
      end
   end

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      ifc.we     = 1'b1;
      ifc.addr   = a;
      ifc.dataIn = d;
      @(posedge clk);
      #1;
      ifc.we = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
      @(negedge clk);
      ifc.addr = a;
      #1;
      chk_eq(nm, ifc.rdata, exp);
   endtask

   task automatic poke(input logic [31:0] byte_a, input logic [31:0] d);
      @(negedge clk);
      pre_a  = byte_a[11:2];
      pre_d  = d;
      pre_en = 1'b1;
      @(posedge clk);
      #1;
      pre_en = 1'b0;
   endtask

   function automatic bit fill_of(input logic [31:0] ctrl);
`ifdef DMA_FILL_EN
      return ctrl[1];
`else
      return 1'b0;
`endif
   endfunction

   // program registers, record the expected words, then write ctrl
   task automatic launch(input logic [31:0] s, input logic [31:0] d, input int n, input logic [31:0] ctrl);
      xfer_t e;
      logic [31:0] ra;
      wr(A_SRC, s);
      wr(A_DST, d);
      wr(A_LEN, 32'(n));
      for (int i = 0; i < n; i++) begin
         ra       = s + 32'(4 * i);
         e.rd_a   = ra;
         e.wr_a   = d + 32'(4 * i);
         e.noread = fill_of(ctrl);
         e.d      = fill_of(ctrl) ? s : mem[ra[11:2]];
         expq.push_back(e);
      end
      irq_cnt  = 0;
      hold_cnt = 0;
      wr(A_CTRL, ctrl);
   endtask

   // cycles from the start edge until done_irq is visible
   task automatic wait_done(output int cnt);
      cnt = 0;
      while (!ifc.done_irq && cnt < 300) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk_bit("done_irq_seen", ifc.done_irq, 1'b1);
   endtask

   task automatic finish_job(input string nm);
      repeat (3) @(posedge clk);
      #1;
      chk_int({nm, "_words_left"}, expq.size(), 0);
      chk_int({nm, "_irq_count"}, irq_cnt, 1);
      chk_bit({nm, "_hold_low"}, ifc.hold, 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          n;
      int          lag;
      logic [31:0] s, d, c;
      bit          found;

      ifc.we     = 1'b0;
      ifc.addr   = '0;
      ifc.dataIn = '0;

      // reset values
      repeat (2) @(negedge clk);
      chk_bit("rst_hold", ifc.hold, 1'b0);
      chk_bit("rst_mem_we", ifc.mem_we, 1'b0);
      chk_bit("rst_busy", ifc.busy, 1'b0);
      chk_bit("rst_irq", ifc.done_irq, 1'b0);
      chk_eq("rst_mem_a", ifc.mem_a, 32'h0);
      chk_eq("rst_mem_d", ifc.mem_d, 32'h0);
      ifc.addr = A_CTRL;
      #1;
      chk_eq("rst_ctrl", ifc.rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      rd_chk("rst_src", A_SRC, 32'h0);
      rd_chk("rst_len", A_LEN, 32'h0);

      // basic copy, grant one cycle after hold
      poke(32'h100, 32'd11);
      poke(32'h104, 32'd22);
      poke(32'h108, 32'd33);
      poke(32'h10C, 32'd44);
      ack_lag = 1;
      launch(32'h100, 32'h200, 4, 32'h1);
      wait_done(lat);
      chk_int("basic_latency", lat, 11);
      finish_job("basic");
      chk_eq("basic_m0", mem[32'h200 >> 2], 32'd11);
      chk_eq("basic_m1", mem[32'h204 >> 2], 32'd22);
      chk_eq("basic_m2", mem[32'h208 >> 2], 32'd33);
      chk_eq("basic_m3", mem[32'h20C >> 2], 32'd44);
      rd_chk("basic_src", A_SRC, 32'h110);
      rd_chk("basic_dst", A_DST, 32'h210);
      rd_chk("basic_len", A_LEN, 32'h0);
      rd_chk("basic_ctrl", A_CTRL, 32'h4);
      rd_chk("unmapped", 5'b00011, 32'h0);

      // clear done, then a zero-length start
      wr(A_CTRL, 32'h4);
      rd_chk("clr_ctrl", A_CTRL, 32'h0);
      launch(32'h100, 32'h200, 0, 32'h1);
      wait_done(lat);
      chk_int("zero_latency", lat, 0);
      finish_job("zero");
      chk_int("zero_hold_cycles", hold_cnt, 0);
      rd_chk("zero_ctrl", A_CTRL, 32'h4);

      // start and clear-done together: start wins, done ends cleared
      launch(32'h100, 32'h240, 2, 32'h5);
      rd_chk("startclr_ctrl", A_CTRL, 32'h2);
      wait_done(lat);
      chk_int("startclr_latency", lat, 7);
      finish_job("startclr");

      // grant withdrawn for 5 cycles during the second read
      poke(32'h140, 32'h1111_0001);
      poke(32'h144, 32'h2222_0002);
      poke(32'h148, 32'h3333_0003);
      gap_addr = 32'h144;
      gap_arm  = 1'b1;
      launch(32'h140, 32'h280, 3, 32'h1);
      wait_done(lat);
      chk_bit("gap_taken", gap_arm, 1'b0);
      finish_job("gap");
      chk_eq("gap_m1", mem[32'h284 >> 2], 32'h2222_0002);
      rd_chk("gap_src", A_SRC, 32'h14C);
      rd_chk("gap_dst", A_DST, 32'h28C);

      // writes while busy are ignored
      poke(32'h400, 32'h5A5A_5A5A);
      launch(32'h100, 32'h500, 4, 32'h1);
      repeat (4) @(posedge clk);
      wr(A_DST, 32'h400);
      wr(A_CTRL, 32'h1);
      wait_done(lat);
      finish_job("busyprot");
      chk_eq("busyprot_sentinel", mem[32'h400 >> 2], 32'h5A5A_5A5A);
      rd_chk("busyprot_dst", A_DST, 32'h510);

      // asynchronous reset in the middle of a write cycle
      launch(32'h100, 32'h600, 4, 32'h1);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         found = ifc.mem_we;
      end
      chk_bit("arst_reached_wr", found, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk_bit("arst_hold", ifc.hold, 1'b0);
      chk_bit("arst_mem_we", ifc.mem_we, 1'b0);
      chk_bit("arst_busy", ifc.busy, 1'b0);
      ifc.addr = A_CTRL;
      #1;
      chk_eq("arst_ctrl", ifc.rdata, 32'h0);
      expq.delete();
      @(negedge clk);
      rst = 1'b0;
      rd_chk("arst_src", A_SRC, 32'h0);

      // ctrl = 3'b011: fill when the feature is built in, plain copy otherwise
      poke(32'hEEC, 32'hA000_0001);
      poke(32'hEF0, 32'hA000_0002);
      poke(32'hEF4, 32'hA000_0003);
      launch(32'hDEAD_BEEF, 32'h300, 3, 32'h3);
      wait_done(lat);
      finish_job("fill");
      rd_chk("fill_dst", A_DST, 32'h30C);
`ifdef DMA_FILL_EN
      chk_int("fill_latency", lat, 6);
      chk_eq("fill_m0", mem[32'h300 >> 2], 32'hDEAD_BEEF);
      chk_eq("fill_m2", mem[32'h308 >> 2], 32'hDEAD_BEEF);
      rd_chk("fill_src", A_SRC, 32'hDEAD_BEEF);
`else
      chk_int("nofill_latency", lat, 9);
      chk_eq("nofill_m0", mem[32'h300 >> 2], 32'hA000_0001);
      chk_eq("nofill_m2", mem[32'h308 >> 2], 32'hA000_0003);
      rd_chk("nofill_src", A_SRC, 32'hDEAD_BEFB);
`endif

      // randomized transfers
      for (int it = 0; it < 8; it++) begin
         lag = $urandom_range(0, 1);
         n   = $urandom_range(1, 6);
         s   = 32'h700 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         d   = 32'h900 + 32'(4 * $urandom_range(0, 15));
         c   = 32'h1 | (32'($urandom_range(0, 1)) << 1);
         for (int i = 0; i < n; i++)
            poke(s + 32'(4 * i), $urandom);
         ack_lag = lag;
         launch(s, d, n, c);
         wait_done(lat);
         chk_int("rand_latency", lat, (fill_of(c) ? n : 2 * n) + 2 + lag);
         finish_job("rand");
         rd_chk("rand_src", A_SRC, fill_of(c) ? s : s + 32'(4 * n));
         rd_chk("rand_dst", A_DST, d + 32'(4 * n));
         rd_chk("rand_ctrl", A_CTRL, 32'h4);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
